rename_unit: RTL and testbench
==============================

# rename_unit

Parametrised register-rename stage that succeeds the single-width `Rename` block. It maps architectural source and destination registers to physical tags through a register alias table (RAT) and allocates new destination tags from a circular free list. It tracks per-tag ready bits and values, with a combinational bypass for wakeups arriving in the same cycle. It sits between decode and the reservation stations. It adds an allocation handshake (stall on empty free list), multiple wakeup and free ports, and an optional branch checkpoint.

## Interface
Parameters:
- `ARCH_REGS`, 32: architectural register count (power of 2).
- `PHYS_REGS`, 64: physical register count (power of 2, > ARCH_REGS).
- `XLEN`, 32: data width.
- `WAKEUP_PORTS`, 2: number of parallel wakeup (result broadcast) ports.
- `FREE_PORTS`, 2: number of parallel tag-return ports from retire.

Derived widths: AW = $clog2(ARCH_REGS), TW = $clog2(PHYS_REGS).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: rename can accept the instruction this cycle.
- `rd_write` in 1: instruction writes `architectural_rd`.
- `architectural_rd`, `architectural_rs1`, `architectural_rs2` in AW each: architectural register numbers.
- `physical_rd` out TW: newly allocated tag; 0 when no allocation occurs.
- `old_physical_rd` out TW: previous mapping of rd, carried to the ROB for freeing at retire.
- `physical_rs1`, `physical_rs2` out TW: source tags.
- `rs1_ready`, `rs2_ready` out 1: source values are available.
- `rs1_value`, `rs2_value` out XLEN: source values; 0 when not ready.
- `wakeup_active` in WAKEUP_PORTS: per-port broadcast valid.
- `wakeup_tag` in WAKEUP_PORTS*TW: tags, flattened with port 0 in the LSBs.
- `wakeup_value` in WAKEUP_PORTS*XLEN: values, flattened likewise.
- `freed_valid` in FREE_PORTS: per-port return valid.
- `freed_tag` in FREE_PORTS*TW: tags returned to the free list.
- `freelist_overflow` out 1: sticky error flag, cleared only by reset.

## Operation
- Architectural register 0 is hardwired to tag 0. Tag 0 is permanently ready with value 0, is never allocated, and is never enqueued.
- Allocation happens when `in_valid && in_ready && rd_write && architectural_rd != 0`. On an allocation:
  - pop the free-list head;
  - update RAT[rd];
  - clear ready[new] and value[new].
- `in_ready` is 1 when the free-list count is nonzero, or when the instruction needs no allocation.
- Sources read the RAT state from before this instruction's rd update, so `add x1,x1,x1` sees the old x1.
- Ready/value per source:
  - stored ready bit OR'd with any same-cycle matching wakeup;
  - on a match, the value comes from the lowest-index matching port;
  - otherwise the value comes from the stored value.
- Wakeup latches ready=1 and the value at the edge.
- Free: each `freed_valid` with a nonzero tag is enqueued at the tail, in port order.
- Enqueue when the free list is full: the tag is dropped and `freelist_overflow` is set.
- Reset:
  - RAT[i] = i;
  - tags 0..ARCH_REGS-1 ready with value 0;
  - free list holds ARCH_REGS..PHYS_REGS-1 in ascending order;
  - count = PHYS_REGS-ARCH_REGS;
  - all outputs settle to the combinational result of this state; `freelist_overflow` = 0.
- Reset has priority over all same-cycle rename, wakeup and free activity.

## Timing
- Rename is zero-latency: all outputs are combinational from the current inputs and state.
- State commits at the next rising edge.
- A tag freed in cycle N is allocatable from cycle N+1; `in_ready` depends only on the registered count.
- A wakeup on the tag being allocated in the same cycle: allocation wins and the tag ends not-ready.
- A wakeup with tag 0 is ignored.
- The free-list head and tail pointers wrap modulo PHYS_REGS.
- Count is updated as count - pop + pushes.

## Configuration
- `RENAME_CHECKPOINT_EN` defined:
  - adds inputs `checkpoint_take` (1) and `checkpoint_restore` (1);
  - take snapshots the RAT and the free-list head pointer as committed at that edge;
  - restore at an edge reloads the RAT and head, discarding allocations made since the snapshot;
  - count is recomputed from the restored head and the current tail;
  - ready bits and tags freed since the snapshot are kept;
  - restore has priority over same-cycle allocation; take together with restore snapshots the restored state.
- `RENAME_CHECKPOINT_EN` not defined: the ports and snapshot storage are absent.

## Structure
- Package `rename_pkg` holds:
  - the tag-width function;
  - the tag 0 constant `ZERO_TAG`;
  - the flattened-port slicing helpers.
- One sub-module, `rename_freelist`: a circular FIFO of TW-bit tags with:
  - one pop port;
  - FREE_PORTS push ports;
  - count, overflow and head-restore interface.

## Test plan
- Reset, then rename `add x1,x0,x1` -> rs1 and rs2 both ready with value 0; `physical_rd` = 32; `old_physical_rd` = 1.
- Two back-to-back writes to x1, then a read of x1 -> rs tag = second tag (33), not ready. Wake tag 32 with 123 -> still not ready. Wake tag 33 with 456 -> ready with value 456 in the same cycle, and still 456 the cycle after.
- Two wakeup ports driving the same tag with 7 and 9 in one cycle -> value 7 is bypassed and stored.
- 32 allocations with no frees -> `in_ready` = 0 on the 33rd while `rd_write` = 1. An `rd_write` = 0 instruction is still accepted. Free tag 5 -> `in_ready` = 1 the next cycle, and the allocation gets 5.
- Free list full and a free of tag 40 -> `freelist_overflow` = 1 and the tag is dropped. Assert reset mid-stream -> identity RAT restored and flag cleared.
- With `RENAME_CHECKPOINT_EN`: take, allocate x2 and x3, then restore -> x2 maps to 2, x3 maps to 3, and the next allocation returns the first tag given out after the take.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared definitions for the register-rename stage: tag width helper,
// the hardwired zero tag, and flattened-port slicing helpers.
package rename_pkg;

  // Tag 0 is architectural register 0: permanently ready, value 0, never allocated.
  localparam int ZERO_TAG = 0;

  // Number of bits needed to name one of `regs` registers.
  function automatic int tag_width(input int regs);
    return (regs > 1) ? $clog2(regs) : 1;
  endfunction

  // LSB position of port `port` inside a bus flattened with port 0 in the LSBs.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rename_freelist.sv
// Circular free list of physical tags: one pop port, FREE_PORTS push ports,
// sticky overflow on a push into a full list.
// Optional macro RENAME_CHECKPOINT_EN adds a head-pointer snapshot/restore.
module rename_freelist
  import rename_pkg::*;
#(
  parameter int PHYS_REGS  = 64,
  parameter int ARCH_REGS  = 32,
  parameter int FREE_PORTS = 2,
  parameter int TW         = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pop,
  input  logic [FREE_PORTS-1:0]    push_valid,
  input  logic [FREE_PORTS*TW-1:0] push_tag,
`ifdef RENAME_CHECKPOINT_EN
  input  logic                     checkpoint_take,
  input  logic                     checkpoint_restore,
`endif
  output logic [TW-1:0]            head_tag,
  output logic [TW:0]              count,
  output logic                     overflow
);

  localparam logic [TW:0] CAPACITY  = (TW+1)'(PHYS_REGS);
  localparam int          INIT_FREE = PHYS_REGS - ARCH_REGS;

  logic [TW-1:0] mem [PHYS_REGS];
  logic [TW-1:0] head, tail, head_next, tail_next;
  logic [TW:0]   running, count_next;
  logic          overflow_set;
  logic [FREE_PORTS-1:0] wr_en;
  logic [TW-1:0] wr_addr [FREE_PORTS];
  logic [TW-1:0] wr_tag  [FREE_PORTS];

`ifdef RENAME_CHECKPOINT_EN
  logic [TW-1:0] snap_head;
  logic [TW-1:0] restore_diff;
`endif

  assign head_tag = mem[head];

  // Pop first, then accept pushes in port order while space remains; zero tags are ignored.
  always_comb begin
    running      = count - (TW+1)'(pop);
    tail_next    = tail;
    overflow_set = 1'b0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      wr_tag[p]  = push_tag[slice_lsb(p, TW) +: TW];
      wr_addr[p] = tail_next;
      wr_en[p]   = 1'b0;
      if (push_valid[p] && (wr_tag[p] != TW'(ZERO_TAG))) begin
        if (running < CAPACITY) begin
          wr_en[p]  = 1'b1;
          tail_next = tail_next + TW'(1);
          running   = running + (TW+1)'(1);
        end else begin
          overflow_set = 1'b1;
        end
      end
    end
    head_next  = head + TW'(pop);
    count_next = running;
`ifdef RENAME_CHECKPOINT_EN
    restore_diff = '0;
    if (checkpoint_restore) begin
      // Restoring only moves the head back, so a zero distance with entries present means full.
      head_next    = snap_head;
      restore_diff = tail_next - snap_head;
      count_next   = ((restore_diff == '0) && (running != '0)) ? CAPACITY : {1'b0, restore_diff};
    end
`endif
  end

  // Commit storage, pointers, count and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= (i < INIT_FREE) ? TW'(ARCH_REGS + i) : '0;
      end
      head     <= '0;
      tail     <= TW'(INIT_FREE);
      count    <= (TW+1)'(INIT_FREE);
      overflow <= 1'b0;
    end else begin
      for (int p = 0; p < FREE_PORTS; p++) begin
        if (wr_en[p]) mem[wr_addr[p]] <= wr_tag[p];
      end
      head     <= head_next;
      tail     <= tail_next;
      count    <= count_next;
      overflow <= overflow | overflow_set;
    end
  end

`ifdef RENAME_CHECKPOINT_EN
  // Snapshot the head as it will stand after this edge (restored value if restoring).
  always_ff @(posedge clk) begin
    if (reset) snap_head <= '0;
    else if (checkpoint_take) snap_head <= head_next;
  end
`endif

endmodule

// File: rtl/rename_unit.sv
// Register-rename stage: RAT lookup, destination allocation from the free
// list, per-tag ready/value tracking with same-cycle wakeup bypass.
// Optional macro RENAME_CHECKPOINT_EN adds checkpoint_take/checkpoint_restore.
//
// Handshake: an instruction transfers on a cycle where in_valid && in_ready.
// in_ready depends only on registered state (free-list count) and on whether
// the offered instruction needs a tag; it never depends on in_valid.
module rename_unit
  import rename_pkg::*;
#(
  parameter int ARCH_REGS    = 32,
  parameter int PHYS_REGS    = 64,
  parameter int XLEN         = 32,
  parameter int WAKEUP_PORTS = 2,
  parameter int FREE_PORTS   = 2,
  localparam int AW = tag_width(ARCH_REGS),
  localparam int TW = tag_width(PHYS_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       rd_write,
  input  logic [AW-1:0]              architectural_rd,
  input  logic [AW-1:0]              architectural_rs1,
  input  logic [AW-1:0]              architectural_rs2,
  output logic [TW-1:0]              physical_rd,
  output logic [TW-1:0]              old_physical_rd,
  output logic [TW-1:0]              physical_rs1,
  output logic [TW-1:0]              physical_rs2,
  output logic                       rs1_ready,
  output logic                       rs2_ready,
  output logic [XLEN-1:0]            rs1_value,
  output logic [XLEN-1:0]            rs2_value,
  input  logic [WAKEUP_PORTS-1:0]    wakeup_active,
  input  logic [WAKEUP_PORTS*TW-1:0] wakeup_tag,
  input  logic [WAKEUP_PORTS*XLEN-1:0] wakeup_value,
  input  logic [FREE_PORTS-1:0]      freed_valid,
  input  logic [FREE_PORTS*TW-1:0]   freed_tag,
`ifdef RENAME_CHECKPOINT_EN
  input  logic                       checkpoint_take,
  input  logic                       checkpoint_restore,
`endif
  output logic                       freelist_overflow
);

  logic [TW-1:0]      rat      [ARCH_REGS];
  logic [TW-1:0]      rat_next [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready_q;
  logic [XLEN-1:0]    value_q  [PHYS_REGS];
  logic [TW-1:0]      head_tag;
  logic [TW:0]        fl_count;
  logic               needs_alloc, alloc, restore_now;
  logic [TW-1:0]      src_tag   [2];
  logic               src_ready [2];
  logic [XLEN-1:0]    src_value [2];

`ifdef RENAME_CHECKPOINT_EN
  logic [TW-1:0] snap_rat [ARCH_REGS];
  assign restore_now = checkpoint_restore;
`else
  assign restore_now = 1'b0;
`endif

  assign needs_alloc     = rd_write && (architectural_rd != '0);
  assign in_ready        = (fl_count != '0) || !needs_alloc;
  assign alloc           = in_valid && in_ready && needs_alloc && !restore_now;
  assign physical_rd     = alloc ? head_tag : TW'(ZERO_TAG);
  assign old_physical_rd = rat[architectural_rd];
  assign physical_rs1    = src_tag[0];
  assign physical_rs2    = src_tag[1];
  assign rs1_ready       = src_ready[0];
  assign rs2_ready       = src_ready[1];
  assign rs1_value       = src_value[0];
  assign rs2_value       = src_value[1];

  // Source lookup on the pre-update RAT, with lowest-index wakeup bypass.
  always_comb begin
    src_tag[0] = rat[architectural_rs1];
    src_tag[1] = rat[architectural_rs2];
    for (int s = 0; s < 2; s++) begin
      src_ready[s] = ready_q[src_tag[s]];
      src_value[s] = value_q[src_tag[s]];
      for (int p = WAKEUP_PORTS-1; p >= 0; p--) begin
        if (wakeup_active[p] && (src_tag[s] != TW'(ZERO_TAG)) &&
            (wakeup_tag[slice_lsb(p, TW) +: TW] == src_tag[s])) begin
          src_ready[s] = 1'b1;
          src_value[s] = wakeup_value[slice_lsb(p, XLEN) +: XLEN];
        end
      end
      if (!src_ready[s]) src_value[s] = '0;
    end
  end

  // Next RAT: a restore replaces the whole table, otherwise an allocation remaps rd.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) rat_next[i] = rat[i];
`ifdef RENAME_CHECKPOINT_EN
    if (checkpoint_restore) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_next[i] = snap_rat[i];
    end
`endif
    if (alloc) rat_next[architectural_rd] = head_tag;
  end

  // RAT and per-tag ready/value state; allocation clears after wakeups so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= TW'(i);
      for (int i = 0; i < PHYS_REGS; i++) begin
        ready_q[i] <= (i < ARCH_REGS);
        value_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= rat_next[i];
      for (int p = WAKEUP_PORTS-1; p >= 0; p--) begin
        if (wakeup_active[p] && (wakeup_tag[slice_lsb(p, TW) +: TW] != TW'(ZERO_TAG))) begin
          ready_q[wakeup_tag[slice_lsb(p, TW) +: TW]] <= 1'b1;
          value_q[wakeup_tag[slice_lsb(p, TW) +: TW]] <= wakeup_value[slice_lsb(p, XLEN) +: XLEN];
        end
      end
      if (alloc) begin
        ready_q[head_tag] <= 1'b0;
        value_q[head_tag] <= '0;
      end
    end
  end

`ifdef RENAME_CHECKPOINT_EN
  // RAT snapshot of the state committed at this edge (restored state when both fire).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) snap_rat[i] <= TW'(i);
    end else if (checkpoint_take) begin
      for (int i = 0; i < ARCH_REGS; i++) snap_rat[i] <= rat_next[i];
    end
  end
`endif

  rename_freelist #(
    .PHYS_REGS  (PHYS_REGS),
    .ARCH_REGS  (ARCH_REGS),
    .FREE_PORTS (FREE_PORTS),
    .TW         (TW)
  ) u_freelist (
    .clk                (clk),
    .reset              (reset),
    .pop                (alloc),
    .push_valid         (freed_valid),
    .push_tag           (freed_tag),
`ifdef RENAME_CHECKPOINT_EN
    .checkpoint_take    (checkpoint_take),
    .checkpoint_restore (checkpoint_restore),
`endif
    .head_tag           (head_tag),
    .count              (fl_count),
    .overflow           (freelist_overflow)
  );

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit with a queue-based reference model.
// Define RENAME_CHECKPOINT_EN for both RTL and bench to cover checkpoints.
module tb_rename_unit;
  localparam int AR = 32, PR = 64, XL = 32, WP = 2, FP = 2, AW = 5, TW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic in_valid, in_ready, rd_write;
  logic [AW-1:0] architectural_rd, architectural_rs1, architectural_rs2;
  logic [TW-1:0] physical_rd, old_physical_rd, physical_rs1, physical_rs2;
  logic rs1_ready, rs2_ready;
  logic [XL-1:0] rs1_value, rs2_value;
  logic [WP-1:0] wakeup_active;
  logic [WP*TW-1:0] wakeup_tag;
  logic [WP*XL-1:0] wakeup_value;
  logic [FP-1:0] freed_valid;
  logic [FP*TW-1:0] freed_tag;
  logic freelist_overflow;
`ifdef RENAME_CHECKPOINT_EN
  logic checkpoint_take, checkpoint_restore;
`endif

  rename_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR), .XLEN(XL), .WAKEUP_PORTS(WP), .FREE_PORTS(FP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .rd_write(rd_write),
    .architectural_rd(architectural_rd), .architectural_rs1(architectural_rs1),
    .architectural_rs2(architectural_rs2), .physical_rd(physical_rd),
    .old_physical_rd(old_physical_rd), .physical_rs1(physical_rs1), .physical_rs2(physical_rs2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .wakeup_active(wakeup_active), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
    .freed_valid(freed_valid), .freed_tag(freed_tag),
`ifdef RENAME_CHECKPOINT_EN
    .checkpoint_take(checkpoint_take), .checkpoint_restore(checkpoint_restore),
`endif
    .freelist_overflow(freelist_overflow)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  int m_rat [AR];
  int snap_rat [AR];
  bit m_ready [PR];
  logic [XL-1:0] m_val [PR];
  int m_fl [$];
  int snap_fl [$];
  int since_take [$];
  bit m_ovf;

  bit e_in_ready, e_alloc, e_r1, e_r2;
  int e_prd, e_old, e_prs1, e_prs2;
  logic [XL-1:0] e_v1, e_v2;

  function automatic bit restore_in();
`ifdef RENAME_CHECKPOINT_EN
    return checkpoint_restore;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit take_in();
`ifdef RENAME_CHECKPOINT_EN
    return checkpoint_take;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < AR; i++) begin m_rat[i] = i; snap_rat[i] = i; end
    for (int i = 0; i < PR; i++) begin m_ready[i] = (i < AR); m_val[i] = '0; end
    m_fl.delete();
    for (int i = AR; i < PR; i++) m_fl.push_back(i);
    snap_fl = m_fl;
    since_take.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void src_lookup(input int tag, output bit rdy, output logic [XL-1:0] val);
    int t;
    rdy = m_ready[tag];
    val = m_val[tag];
    for (int p = 0; p < WP; p++) begin
      t = int'(wakeup_tag[p*TW +: TW]);
      if (wakeup_active[p] && tag != 0 && t == tag) begin
        rdy = 1'b1;
        val = wakeup_value[p*XL +: XL];
        break;
      end
    end
    if (!rdy) val = '0;
  endfunction

  function automatic void model_predict();
    bit needs;
    needs = rd_write && (architectural_rd != 0);
    e_in_ready = (m_fl.size() != 0) || !needs;
    e_alloc = in_valid && e_in_ready && needs && !restore_in();
    e_prd = 0;
    if (e_alloc) e_prd = m_fl[0];
    e_old = m_rat[architectural_rd];
    e_prs1 = m_rat[architectural_rs1];
    e_prs2 = m_rat[architectural_rs2];
    src_lookup(e_prs1, e_r1, e_v1);
    src_lookup(e_prs2, e_r2, e_v2);
  endfunction

  function automatic void model_commit();
    int t;
    model_predict();
    if (reset) begin model_reset(); return; end
    for (int p = WP-1; p >= 0; p--) begin
      t = int'(wakeup_tag[p*TW +: TW]);
      if (wakeup_active[p] && t != 0) begin m_ready[t] = 1'b1; m_val[t] = wakeup_value[p*XL +: XL]; end
    end
    if (e_alloc) begin
      t = m_fl.pop_front();
      m_ready[t] = 1'b0; m_val[t] = '0;
      m_rat[architectural_rd] = t;
    end
    if (restore_in()) begin
      m_rat = snap_rat;
      m_fl = snap_fl;
      foreach (since_take[k]) m_fl.push_back(since_take[k]);
    end
    for (int p = 0; p < FP; p++) begin
      t = int'(freed_tag[p*TW +: TW]);
      if (freed_valid[p] && t != 0) begin
        if (m_fl.size() < PR) begin m_fl.push_back(t); since_take.push_back(t); end
        else m_ovf = 1'b1;
      end
    end
    if (take_in()) begin snap_rat = m_rat; snap_fl = m_fl; since_take.delete(); end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 0; rd_write = 0;
    architectural_rd = '0; architectural_rs1 = '0; architectural_rs2 = '0;
    wakeup_active = '0; wakeup_tag = '0; wakeup_value = '0;
    freed_valid = '0; freed_tag = '0;
`ifdef RENAME_CHECKPOINT_EN
    checkpoint_take = 0; checkpoint_restore = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic set_wake(input int p, input bit act, input int tag, input logic [XL-1:0] val);
    wakeup_active[p] = act;
    wakeup_tag[p*TW +: TW] = TW'(tag);
    wakeup_value[p*XL +: XL] = val;
  endtask

  task automatic set_alloc(input int rd);
    idle_inputs();
    in_valid = 1; rd_write = 1; architectural_rd = AW'(rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int exp1, exp2;
    do_reset();
    #1;
    tests_run++;
    if ({in_ready, physical_rd, freelist_overflow} !== {1'b1, 6'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl got rdy=%b prd=%0d ovf=%b exp 1 0 0", in_ready, physical_rd, freelist_overflow);
    end
    for (int i = 0; i < 4; i++) begin
      exp1 = i * 7 + 1; exp2 = 31 - i * 9;
      architectural_rs1 = AW'(exp1); architectural_rs2 = AW'(exp2);
      #1;
      tests_run++;
      if ({physical_rs1, physical_rs2, rs1_ready, rs2_ready, rs1_value, rs2_value} !==
          {TW'(exp1), TW'(exp2), 1'b1, 1'b1, 32'd0, 32'd0}) begin
        tests_failed++;
        $display("FAIL reset_rat got %0d/%0d rdy=%b%b exp %0d/%0d rdy=11", physical_rs1, physical_rs2,
                 rs1_ready, rs2_ready, exp1, exp2);
      end
    end
    tick();
  endtask

  task automatic test_add_x1();
    do_reset();
    set_alloc(1); architectural_rs1 = 0; architectural_rs2 = 1;
    #1;
    tests_run++;
    if ({rs1_ready, rs2_ready, rs1_value, rs2_value} !== {1'b1, 1'b1, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL add_src got rdy=%b%b v=%0d/%0d exp rdy=11 v=0/0", rs1_ready, rs2_ready, rs1_value, rs2_value);
    end
    tests_run++;
    if ({physical_rd, old_physical_rd} !== {6'd32, 6'd1}) begin
      tests_failed++;
      $display("FAIL add_tags got prd=%0d old=%0d exp 32 1", physical_rd, old_physical_rd);
    end
    tick();
  endtask

  task automatic test_wakeup_bypass();
    do_reset();
    set_alloc(1); tick();
    set_alloc(1);
    #1;
    tests_run++;
    if ({physical_rd, old_physical_rd} !== {6'd33, 6'd32}) begin
      tests_failed++;
      $display("FAIL second_x1 got prd=%0d old=%0d exp 33 32", physical_rd, old_physical_rd);
    end
    tick();
    idle_inputs(); in_valid = 1; architectural_rs1 = 1;
    set_wake(0, 1, 32, 123);
    #1;
    tests_run++;
    if ({physical_rs1, rs1_ready, rs1_value} !== {6'd33, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL read_x1_old_wake got tag=%0d rdy=%b v=%0d exp 33 0 0", physical_rs1, rs1_ready, rs1_value);
    end
    tick();
    set_wake(0, 1, 33, 456);
    #1;
    tests_run++;
    if ({rs1_ready, rs1_value} !== {1'b1, 32'd456}) begin
      tests_failed++;
      $display("FAIL bypass_x1 got rdy=%b v=%0d exp 1 456", rs1_ready, rs1_value);
    end
    tick();
    set_wake(0, 0, 0, 0);
    #1;
    tests_run++;
    if ({rs1_ready, rs1_value} !== {1'b1, 32'd456}) begin
      tests_failed++;
      $display("FAIL stored_x1 got rdy=%b v=%0d exp 1 456", rs1_ready, rs1_value);
    end
    tick();
  endtask

  task automatic test_wake_corner();
    do_reset();
    set_alloc(5); tick();
    set_alloc(6); tick();
    idle_inputs(); in_valid = 1; architectural_rs1 = 5; architectural_rs2 = 6;
    set_wake(0, 1, 32, 7); set_wake(1, 1, 32, 9);
    #1;
    tests_run++;
    if ({rs1_ready, rs1_value, rs2_ready} !== {1'b1, 32'd7, 1'b0}) begin
      tests_failed++;
      $display("FAIL dual_wake got rdy=%b v=%0d rs2rdy=%b exp 1 7 0", rs1_ready, rs1_value, rs2_ready);
    end
    tick();
    set_wake(0, 0, 33, 11); set_wake(1, 1, 33, 9);
    #1;
    tests_run++;
    if ({rs1_ready, rs1_value, rs2_ready, rs2_value} !== {1'b1, 32'd7, 1'b1, 32'd9}) begin
      tests_failed++;
      $display("FAIL stored_7_port1 got v1=%0d rdy2=%b v2=%0d exp 7 1 9", rs1_value, rs2_ready, rs2_value);
    end
    tick();
    // Allocation of tag 34 collides with a wakeup of 34; tag 0 wakeup ignored.
    set_alloc(7); set_wake(0, 1, 34, 77); set_wake(1, 1, 0, 55);
    #1;
    tests_run++;
    if ({physical_rd, rs1_ready, rs1_value} !== {6'd34, 1'b1, 32'd0}) begin
      tests_failed++;
      $display("FAIL alloc_wake got prd=%0d x0rdy=%b x0v=%0d exp 34 1 0", physical_rd, rs1_ready, rs1_value);
    end
    tick();
    idle_inputs(); architectural_rs1 = 7; architectural_rs2 = 0;
    #1;
    tests_run++;
    if ({physical_rs1, rs1_ready, rs2_ready, rs2_value} !== {6'd34, 1'b0, 1'b1, 32'd0}) begin
      tests_failed++;
      $display("FAIL alloc_wins got tag=%0d rdy=%b x0rdy=%b x0v=%0d exp 34 0 1 0", physical_rs1, rs1_ready,
               rs2_ready, rs2_value);
    end
    tick();
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_alloc(i % 31 + 1);
      #1;
      tests_run++;
      if (physical_rd !== TW'(32 + i)) begin
        tests_failed++;
        $display("FAIL exhaust_alloc%0d got %0d exp %0d", i, physical_rd, 32 + i);
      end
      tick();
    end
    set_alloc(3);
    #1;
    tests_run++;
    if ({in_ready, physical_rd} !== {1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL empty_stall got rdy=%b prd=%0d exp 0 0", in_ready, physical_rd);
    end
    rd_write = 0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_nowrite got rdy=%b exp 1", in_ready);
    end
    tick();
    set_alloc(3); freed_valid = 2'b10; freed_tag = {6'd5, 6'd0};
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_same_cycle got rdy=%b exp 0", in_ready);
    end
    tick();
    set_alloc(3);
    #1;
    tests_run++;
    if ({in_ready, physical_rd} !== {1'b1, 6'd5}) begin
      tests_failed++;
      $display("FAIL realloc5 got rdy=%b prd=%0d exp 1 5", in_ready, physical_rd);
    end
    tick();
  endtask

  task automatic test_overflow();
    int exp;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle_inputs(); freed_valid = 2'b11; freed_tag = {TW'(2 * i + 2), TW'(2 * i + 1)};
      tick();
    end
    idle_inputs();
    #1;
    tests_run++;
    if (freelist_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_no_ovf got %b exp 0", freelist_overflow);
    end
    freed_valid = 2'b01; freed_tag = {6'd0, 6'd40};
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (freelist_overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set got %b exp 1", freelist_overflow);
    end
    for (int i = 0; i < 64; i++) begin
      exp = (i < 32) ? 32 + i : i - 31;
      set_alloc(i % 31 + 1);
      #1;
      tests_run++;
      if (physical_rd !== TW'(exp)) begin
        tests_failed++;
        $display("FAIL drain%0d got %0d exp %0d", i, physical_rd, exp);
      end
      tick();
    end
    set_alloc(2);
    #1;
    tests_run++;
    if ({in_ready, freelist_overflow} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL dropped40 got rdy=%b ovf=%b exp 0 1", in_ready, freelist_overflow);
    end
  endtask

  task automatic test_mid_reset();
    set_alloc(3); freed_valid = 2'b11; freed_tag = {6'd9, 6'd12}; set_wake(0, 1, 3, 99);
    reset = 1;
    tick();
    reset = 0;
    idle_inputs(); architectural_rs1 = 3; architectural_rs2 = 9;
    #1;
    tests_run++;
    if ({freelist_overflow, physical_rs1, physical_rs2, rs1_ready, rs1_value} !==
        {1'b0, 6'd3, 6'd9, 1'b1, 32'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset got ovf=%b %0d/%0d rdy=%b v=%0d exp 0 3/9 1 0", freelist_overflow,
               physical_rs1, physical_rs2, rs1_ready, rs1_value);
    end
    set_alloc(3);
    #1;
    tests_run++;
    if ({physical_rd, old_physical_rd} !== {6'd32, 6'd3}) begin
      tests_failed++;
      $display("FAIL post_reset_alloc got prd=%0d old=%0d exp 32 3", physical_rd, old_physical_rd);
    end
    tick();
  endtask

  task automatic test_random();
    logic [91:0] obs, exp;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      idle_inputs();
      in_valid = ($urandom_range(0, 9) < 8);
      rd_write = ($urandom_range(0, 9) < 7);
      architectural_rd = AW'($urandom_range(0, AR - 1));
      architectural_rs1 = AW'($urandom_range(0, AR - 1));
      architectural_rs2 = AW'($urandom_range(0, AR - 1));
      for (int p = 0; p < WP; p++) set_wake(p, $urandom_range(0, 1), $urandom_range(0, PR - 1), $urandom);
      for (int p = 0; p < FP; p++) begin
        freed_valid[p] = ($urandom_range(0, 3) == 0);
        freed_tag[p*TW +: TW] = TW'($urandom_range(0, PR - 1));
      end
      #1;
      model_predict();
      obs = {in_ready, physical_rd, old_physical_rd, physical_rs1, physical_rs2, rs1_ready, rs2_ready,
             rs1_value, rs2_value, freelist_overflow};
      exp = {e_in_ready, TW'(e_prd), TW'(e_old), TW'(e_prs1), TW'(e_prs2), e_r1, e_r2, e_v1, e_v2, m_ovf};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL random cyc%0d got %h exp %h", c, obs, exp);
      end
      tick();
    end
  endtask

`ifdef RENAME_CHECKPOINT_EN
  task automatic test_checkpoint();
    do_reset();
    idle_inputs(); checkpoint_take = 1;
    tick();
    set_alloc(2);
    #1;
    tests_run++;
    if (physical_rd !== 6'd32) begin
      tests_failed++;
      $display("FAIL ckpt_alloc_x2 got %0d exp 32", physical_rd);
    end
    tick();
    set_alloc(3); tick();
    set_alloc(5); checkpoint_restore = 1;
    #1;
    tests_run++;
    if (physical_rd !== 6'd0) begin
      tests_failed++;
      $display("FAIL restore_blocks_alloc got %0d exp 0", physical_rd);
    end
    tick();
    idle_inputs(); architectural_rs1 = 2; architectural_rs2 = 3;
    #1;
    tests_run++;
    if ({physical_rs1, physical_rs2} !== {6'd2, 6'd3}) begin
      tests_failed++;
      $display("FAIL restore_rat got %0d/%0d exp 2/3", physical_rs1, physical_rs2);
    end
    set_alloc(4);
    #1;
    model_predict();
    tests_run++;
    if ({physical_rd, old_physical_rd} !== {6'd32, 6'd4} || physical_rd !== TW'(e_prd)) begin
      tests_failed++;
      $display("FAIL restore_head got prd=%0d old=%0d exp 32 4", physical_rd, old_physical_rd);
    end
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_add_x1();
    test_wakeup_bypass();
    test_wake_corner();
    test_exhaust();
    test_overflow();
    test_mid_reset();
    test_random();
`ifdef RENAME_CHECKPOINT_EN
    test_checkpoint();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
